// File: rtl/reorder_buffer.sv
// Circular reorder buffer: allocates rename tags in program order, captures results from the
// ALU/MEM/MUL writeback buses, serves operand lookups and retires one entry per cycle in order.
module reorder_buffer #(
    parameter int ROB_ENTRIES         = 8,
    parameter int ROB_ENTRY_WIDTH     = 3,
    parameter int WORD_SIZE           = 32,
    parameter int ARCH_REG_INDEX_SIZE = 5
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           require_rob_entry,
    input  logic                           is_store,
    input  logic [ARCH_REG_INDEX_SIZE-1:0] rd,
    input  logic                           stall_in,
    input  logic                           flush,
    output logic [ROB_ENTRY_WIDTH-1:0]     assigned_rob_id,
    output logic                           full,
    input  logic [ROB_ENTRY_WIDTH-1:0]     rs1_rob_entry,
    input  logic [ROB_ENTRY_WIDTH-1:0]     rs2_rob_entry,
    output logic [WORD_SIZE-1:0]           rob_s1_data,
    output logic [WORD_SIZE-1:0]           rob_s2_data,
    output logic                           rob_s1_valid,
    output logic                           rob_s2_valid,
    input  logic [WORD_SIZE-1:0]           alu_wb_data,
    input  logic [WORD_SIZE-1:0]           mem_wb_data,
    input  logic [WORD_SIZE-1:0]           mul_wb_data,
    input  logic [ROB_ENTRY_WIDTH-1:0]     alu_wb_rob_id,
    input  logic [ROB_ENTRY_WIDTH-1:0]     mem_wb_rob_id,
    input  logic [ROB_ENTRY_WIDTH-1:0]     mul_wb_rob_id,
    input  logic                           alu_wb_bypass_enable,
    input  logic                           mem_wb_bypass_enable,
    input  logic                           mul_wb_bypass_enable,
    output logic                           commit,
    output logic [ARCH_REG_INDEX_SIZE-1:0] commit_rd,
    output logic [ROB_ENTRY_WIDTH-1:0]     commit_rob_id,
    output logic [WORD_SIZE-1:0]           din,
    output logic                           store_commit,
    output logic                           empty
);

    typedef logic [ROB_ENTRY_WIDTH-1:0] rob_id_t;
    typedef logic [ROB_ENTRY_WIDTH:0]   rob_cnt_t;

    localparam rob_cnt_t COUNT_FULL = rob_cnt_t'(ROB_ENTRIES);

    logic [ROB_ENTRIES-1:0]         valid_q;
    logic [ROB_ENTRIES-1:0]         ready_q;
    logic [ROB_ENTRIES-1:0]         store_q;
    logic [ARCH_REG_INDEX_SIZE-1:0] rd_q   [ROB_ENTRIES];
    logic [WORD_SIZE-1:0]           data_q [ROB_ENTRIES];
    rob_id_t                        head_q, head_d;
    rob_id_t                        tail_q, tail_d;
    rob_cnt_t                       count_q, count_d;

    logic                   alloc;
    logic                   retire;
    logic [ROB_ENTRIES-1:0] wb_hit;
    logic [WORD_SIZE-1:0]   wb_data [ROB_ENTRIES];

    assign full            = (count_q == COUNT_FULL);
    assign empty           = (count_q == '0);
    assign assigned_rob_id = tail_q;

    assign alloc  = require_rob_entry & ~full & ~stall_in & ~flush;
    assign retire = valid_q[head_q] & ready_q[head_q] & ~flush;

    assign commit        = retire & ~store_q[head_q];
    assign store_commit  = retire &  store_q[head_q];
    assign commit_rd     = retire ? rd_q[head_q]   : '0;
    assign commit_rob_id = retire ? head_q         : '0;
    assign din           = retire ? data_q[head_q] : '0;

    assign rob_s1_data  = data_q[rs1_rob_entry];
    assign rob_s2_data  = data_q[rs2_rob_entry];
    assign rob_s1_valid = valid_q[rs1_rob_entry] & ready_q[rs1_rob_entry];
    assign rob_s2_valid = valid_q[rs2_rob_entry] & ready_q[rs2_rob_entry];

    // Per-entry writeback select; ALU wins over MEM, MEM over MUL on a shared ID.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        wb_hit = '0;
        for (int i = 0; i < ROB_ENTRIES; i++) begin
            wb_data[i] = '0;
            if (valid_q[i]) begin
                if (alu_wb_bypass_enable && alu_wb_rob_id == rob_id_t'(i)) begin
                    wb_hit[i]  = 1'b1;
                    wb_data[i] = alu_wb_data;
                end else if (mem_wb_bypass_enable && mem_wb_rob_id == rob_id_t'(i)) begin
                    wb_hit[i]  = 1'b1;
                    wb_data[i] = mem_wb_data;
                end else if (mul_wb_bypass_enable && mul_wb_rob_id == rob_id_t'(i)) begin
                    wb_hit[i]  = 1'b1;
                    wb_data[i] = mul_wb_data;
                end
            end
        end
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (retire) head_d = head_q + rob_id_t'(1);
            if (alloc)  tail_d = tail_q + rob_id_t'(1);
            count_d = count_q + rob_cnt_t'(alloc) - rob_cnt_t'(retire);
        end
    end

    // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            ready_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (flush) begin
                valid_q <= '0;
                ready_q <= '0;
            end else begin
                ready_q <= ready_q | wb_hit;
                if (retire) valid_q[head_q] <= 1'b0;
                if (alloc) begin
                    valid_q[tail_q] <= 1'b1;
                    ready_q[tail_q] <= 1'b0;
                end
            end
        end
    end

    // NOTE: the payload storage has no reset; valid/ready gate every use of it.
    always_ff @(posedge clk) begin
        if (!flush) begin
            for (int i = 0; i < ROB_ENTRIES; i++) begin
                if (alloc && tail_q == rob_id_t'(i)) begin
                    store_q[i] <= is_store;
                    rd_q[i]    <= rd;
                    data_q[i]  <= '0;
                end else if (wb_hit[i]) begin
                    data_q[i]  <= wb_data[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Scoreboard bench for reorder_buffer: directed scenarios followed by random traffic, checked
// against a queue-based in-order model; a negedge monitor compares every retirement and status.
module tb_reorder_buffer;
    localparam int N  = 8;
    localparam int EW = 3;
    localparam int W  = 32;
    localparam int RW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          require_rob_entry, is_store, stall_in, flush;
    logic [RW-1:0] rd;
    logic [EW-1:0] assigned_rob_id, rs1_rob_entry, rs2_rob_entry;
    logic          full, empty, rob_s1_valid, rob_s2_valid;
    logic [W-1:0]  rob_s1_data, rob_s2_data, alu_wb_data, mem_wb_data, mul_wb_data, din;
    logic [EW-1:0] alu_wb_rob_id, mem_wb_rob_id, mul_wb_rob_id, commit_rob_id;
    logic          alu_wb_bypass_enable, mem_wb_bypass_enable, mul_wb_bypass_enable;
    logic          commit, store_commit;
    logic [RW-1:0] commit_rd;

    reorder_buffer #(.ROB_ENTRIES(N), .ROB_ENTRY_WIDTH(EW), .WORD_SIZE(W), .ARCH_REG_INDEX_SIZE(RW)) dut (
        .clk(clk), .rst(rst), .require_rob_entry(require_rob_entry), .is_store(is_store), .rd(rd),
        .stall_in(stall_in), .flush(flush), .assigned_rob_id(assigned_rob_id), .full(full),
        .rs1_rob_entry(rs1_rob_entry), .rs2_rob_entry(rs2_rob_entry),
        .rob_s1_data(rob_s1_data), .rob_s2_data(rob_s2_data),
        .rob_s1_valid(rob_s1_valid), .rob_s2_valid(rob_s2_valid),
        .alu_wb_data(alu_wb_data), .mem_wb_data(mem_wb_data), .mul_wb_data(mul_wb_data),
        .alu_wb_rob_id(alu_wb_rob_id), .mem_wb_rob_id(mem_wb_rob_id), .mul_wb_rob_id(mul_wb_rob_id),
        .alu_wb_bypass_enable(alu_wb_bypass_enable), .mem_wb_bypass_enable(mem_wb_bypass_enable),
        .mul_wb_bypass_enable(mul_wb_bypass_enable), .commit(commit), .commit_rd(commit_rd),
        .commit_rob_id(commit_rob_id), .din(din), .store_commit(store_commit), .empty(empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [EW-1:0] id;
        logic [RW-1:0] rd;
        logic          st;
    } exp_t;

    exp_t         exp_q[$];   // expected retirements, popped by the monitor
    int           rob_m[$];   // in-flight IDs in program order
    bit           m_valid [N];
    bit           m_ready [N];
    logic [W-1:0] m_data  [N];
    int           m_tail;
    int           total = 0;
    int           bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        rob_m.delete();
        exp_q.delete();
        m_tail = 0;
        for (int i = 0; i < N; i++) begin
            m_valid[i] = 1'b0;
            m_ready[i] = 1'b0;
            m_data[i]  = '0;
        end
    endfunction

    // Applies the effect of one clock edge using the inputs currently driven.
    function automatic void model_step();
        int   pre_size = rob_m.size();
        bit   do_retire = (pre_size > 0) && m_ready[rob_m[0]] && !flush;
        exp_t e;
        if (flush) begin
            model_reset();
            return;
        end
        if (mul_wb_bypass_enable && m_valid[mul_wb_rob_id]) begin
            m_ready[mul_wb_rob_id] = 1'b1; m_data[mul_wb_rob_id] = mul_wb_data;
        end
        if (mem_wb_bypass_enable && m_valid[mem_wb_rob_id]) begin
            m_ready[mem_wb_rob_id] = 1'b1; m_data[mem_wb_rob_id] = mem_wb_data;
        end
        if (alu_wb_bypass_enable && m_valid[alu_wb_rob_id]) begin
            m_ready[alu_wb_rob_id] = 1'b1; m_data[alu_wb_rob_id] = alu_wb_data;
        end
        if (do_retire) begin
            m_valid[rob_m[0]] = 1'b0;
            void'(rob_m.pop_front());
        end
        if (require_rob_entry && !stall_in && pre_size < N) begin
            rob_m.push_back(m_tail);
            m_valid[m_tail] = 1'b1;
            m_ready[m_tail] = 1'b0;
            m_data[m_tail]  = '0;
            e.id = EW'(m_tail);
            e.rd = rd;
            e.st = is_store;
            exp_q.push_back(e);
            m_tail = (m_tail + 1) % N;
        end
    endfunction

    task automatic set_idle();
        require_rob_entry = 1'b0; is_store = 1'b0; rd = '0; stall_in = 1'b0; flush = 1'b0;
        rs1_rob_entry = '0; rs2_rob_entry = '0;
        alu_wb_bypass_enable = 1'b0; mem_wb_bypass_enable = 1'b0; mul_wb_bypass_enable = 1'b0;
        alu_wb_rob_id = '0; mem_wb_rob_id = '0; mul_wb_rob_id = '0;
        alu_wb_data = '0; mem_wb_data = '0; mul_wb_data = '0;
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        set_idle();
    endtask

    task automatic alloc_one(input logic [RW-1:0] r, input logic st);
        require_rob_entry = 1'b1; rd = r; is_store = st;
        step();
    endtask

    task automatic alu_wb(input int id, input logic [W-1:0] d);
        alu_wb_bypass_enable = 1'b1; alu_wb_rob_id = EW'(id); alu_wb_data = d;
    endtask

    // Monitor: status outputs, lookups and every retirement against the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        bit   exp_ret;
        exp_ret = (rob_m.size() > 0) && m_ready[rob_m[0]] && !flush;
        check("full", full, rob_m.size() == N);
        check("empty", empty, rob_m.size() == 0);
        check("assigned_rob_id", assigned_rob_id, m_tail);
        check("retire", commit | store_commit, exp_ret);
        check("lookup1_valid", rob_s1_valid, m_valid[rs1_rob_entry] && m_ready[rs1_rob_entry]);
        check("lookup2_valid", rob_s2_valid, m_valid[rs2_rob_entry] && m_ready[rs2_rob_entry]);
        if (m_valid[rs1_rob_entry] && m_ready[rs1_rob_entry])
            check("lookup1_data", rob_s1_data, m_data[rs1_rob_entry]);
        if (m_valid[rs2_rob_entry] && m_ready[rs2_rob_entry])
            check("lookup2_data", rob_s2_data, m_data[rs2_rob_entry]);
        if (commit | store_commit) begin
            check("sb_has_entry", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("commit_rob_id", commit_rob_id, e.id);
                check("commit_rd", commit_rd, e.rd);
                check("store_commit", store_commit, e.st);
                check("commit_ready", m_ready[e.id], 1);
                check("din", din, m_data[e.id]);
            end
        end else begin
            check("idle_din", din, 0);
            check("idle_commit_rd", commit_rd, 0);
            check("idle_commit_rob_id", commit_rob_id, 0);
        end
    end

    initial begin
        int id;
        set_idle();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_full", full, 0);
        check("rst_empty", empty, 1);
        check("rst_assigned", assigned_rob_id, 0);
        check("rst_commit", commit, 0);
        check("rst_store_commit", store_commit, 0);
        check("rst_din", din, 0);
        check("rst_s1_valid", rob_s1_valid, 0);
        rst = 1'b1;

        // Basic alloc -> writeback -> commit
        require_rob_entry = 1'b1; rd = 5'd5;
        #1 check("t1_assigned", assigned_rob_id, 0);
        step();
        alu_wb(0, 32'h1234);
        step();
        check("t1_commit", commit, 1);
        check("t1_commit_rd", commit_rd, 5);
        check("t1_commit_id", commit_rob_id, 0);
        check("t1_din", din, 32'h1234);
        step();
        check("t1_empty", empty, 1);

        // Fill to full, blocked allocation, retire frees a slot
        begin
            model_step(); // model is empty and inputs are idle, so this leaves its state unchanged
        end
        id = m_tail;
        for (int i = 0; i < N; i++) alloc_one(RW'(i + 1), 1'b0);
        check("t2_full", full, 1);
        require_rob_entry = 1'b1; rd = 5'd30;
        step();
        check("t2_tail_held", assigned_rob_id, id);
        alu_wb(id, 32'h55);
        step();
        require_rob_entry = 1'b1; rd = 5'd31;
        #1 check("t2_full_while_retiring", full, 1);
        check("t2_commit", commit, 1);
        step();
        check("t2_full_dropped", full, 0);
        check("t2_next_id", assigned_rob_id, id);
        alloc_one(5'd12, 1'b0);
        check("t2_full_again", full, 1);
        for (int i = 1; i <= N; i++) begin
            alu_wb((id + i) % N, 32'(i));
            step();
        end
        repeat (3) step();
        check("t2_drained", empty, 1);

        // Out-of-order completion retires in order
        flush = 1'b1; step();
        for (int i = 0; i < 3; i++) alloc_one(RW'(i + 20), 1'b0);
        mul_wb_bypass_enable = 1'b1; mul_wb_rob_id = 3'd2; mul_wb_data = 32'd7; step();
        alu_wb(1, 32'd6); step();
        mem_wb_bypass_enable = 1'b1; mem_wb_rob_id = 3'd0; mem_wb_data = 32'd5; step();
        check("t3_c0_id", commit_rob_id, 0); check("t3_c0_din", din, 5); step();
        check("t3_c1_id", commit_rob_id, 1); check("t3_c1_din", din, 6); step();
        check("t3_c2_id", commit_rob_id, 2); check("t3_c2_din", din, 7); step();

        // Store retirement
        alloc_one(5'd9, 1'b1);
        mem_wb_bypass_enable = 1'b1; mem_wb_rob_id = 3'd3; mem_wb_data = 32'h77; step();
        check("t4_store_commit", store_commit, 1);
        check("t4_commit", commit, 0);
        step();

        // Lookups, then flush with live entries and same-cycle traffic
        flush = 1'b1; step();
        for (int i = 0; i < 6; i++) alloc_one(RW'(i + 1), 1'b0);
        alu_wb(3, 32'hAB);
        mem_wb_bypass_enable = 1'b1; mem_wb_rob_id = 3'd0; mem_wb_data = 32'h11;
        step();
        rs1_rob_entry = 3'd3; rs2_rob_entry = 3'd4;
        #1;
        check("t5_s1_valid", rob_s1_valid, 1);
        check("t5_s1_data", rob_s1_data, 32'hAB);
        check("t5_s2_valid", rob_s2_valid, 0);
        step();
        alu_wb(1, 32'h22); step();
        flush = 1'b1; require_rob_entry = 1'b1; rd = 5'd7;
        mem_wb_bypass_enable = 1'b1; mem_wb_rob_id = 3'd2; mem_wb_data = 32'h33;
        #1 check("t6_commit_forced", commit, 0);
        step();
        check("t6_empty", empty, 1);
        check("t6_assigned", assigned_rob_id, 0);
        check("t6_commit", commit, 0);

        // Wrap-around: 20 alloc/retire pairs
        for (int i = 0; i < 20; i++) begin
            require_rob_entry = 1'b1; rd = RW'(i);
            #1 check("t7_wrap_id", assigned_rob_id, i % N);
            step();
            alu_wb(i % N, 32'(i * 3));
            step();
            step();
        end

        // Same-ID collision on all three ports
        id = m_tail;
        alloc_one(5'd4, 1'b0);
        alu_wb(id, 32'hA1);
        mem_wb_bypass_enable = 1'b1; mem_wb_rob_id = EW'(id); mem_wb_data = 32'hB2;
        mul_wb_bypass_enable = 1'b1; mul_wb_rob_id = EW'(id); mul_wb_data = 32'hC3;
        step();
        check("t8_priority_din", din, 32'hA1);
        step();

        // Random traffic with a mid-run asynchronous reset
        for (int c = 0; c < 800; c++) begin
            if (c == 400) begin
                alu_wb(rob_m.size() > 0 ? rob_m[0] : 0, 32'hDEAD);
                rst = 1'b0;
                model_reset();
                #1;
                check("mid_rst_empty", empty, 1);
                check("mid_rst_full", full, 0);
                check("mid_rst_assigned", assigned_rob_id, 0);
                check("mid_rst_commit", commit, 0);
                set_idle();
                repeat (2) @(posedge clk);
                #1 rst = 1'b1;
            end
            require_rob_entry = ($urandom_range(0, 99) < 60);
            rd = RW'($urandom);
            is_store = ($urandom_range(0, 99) < 20);
            stall_in = ($urandom_range(0, 99) < 10);
            flush = ($urandom_range(0, 199) < 3);
            rs1_rob_entry = EW'($urandom);
            rs2_rob_entry = EW'($urandom);
            if (rob_m.size() > 0) begin
                if ($urandom_range(0, 99) < 40) begin
                    alu_wb_bypass_enable = 1'b1;
                    alu_wb_rob_id = EW'(rob_m[$urandom_range(0, rob_m.size() - 1)]);
                    alu_wb_data = $urandom;
                end
                if ($urandom_range(0, 99) < 40) begin
                    mem_wb_bypass_enable = 1'b1;
                    mem_wb_rob_id = EW'(rob_m[$urandom_range(0, rob_m.size() - 1)]);
                    mem_wb_data = $urandom;
                end
                if ($urandom_range(0, 99) < 40) begin
                    mul_wb_bypass_enable = 1'b1;
                    mul_wb_rob_id = EW'($urandom);
                    mul_wb_data = $urandom;
                end
                if ($urandom_range(0, 99) < 10) begin
                    mem_wb_rob_id = alu_wb_rob_id;
                    mul_wb_rob_id = alu_wb_rob_id;
                end
            end
            step();
        end

        // Drain: complete the oldest entry each cycle, bounded
        for (int c = 0; c < 100 && rob_m.size() > 0; c++) begin
            alu_wb(rob_m[0], $urandom);
            step();
        end
        step();
        check("drain_scoreboard", exp_q.size(), 0);
        check("drain_empty", empty, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- Circular reorder buffer at the far end of the decode-stage ROB interface.
- Allocates an entry to each decoded instruction that writes back and returns its ID as the rename tag.
- Captures results from the ALU, MEM and MUL writeback buses and serves operand values looked up by ROB ID.
- Retires entries strictly in order, driving the register-file write and rename-table release.

Parameters:
- ROB_ENTRIES, 8, number of entries; must be a power of two.
- ROB_ENTRY_WIDTH, 3, log2(ROB_ENTRIES); ROB ID width.
- WORD_SIZE, 32, data width.
- ARCH_REG_INDEX_SIZE, 5, architectural register index width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-low.
- require_rob_entry  in  1  decode requests an allocation.
- is_store  in  1  the instruction being allocated is a store.
- rd  in  ARCH_REG_INDEX_SIZE  destination register of the allocation.
- stall_in  in  1  blocks allocation this cycle.
- flush  in  1  discards all entries.
- assigned_rob_id  out  ROB_ENTRY_WIDTH  tail pointer; the ID given to the next allocation.
- full  out  1  count == ROB_ENTRIES.
- rs1_rob_entry, rs2_rob_entry  in  ROB_ENTRY_WIDTH  operand lookup IDs.
- rob_s1_data, rob_s2_data  out  WORD_SIZE  looked-up entry data.
- rob_s1_valid, rob_s2_valid  out  1  looked-up entry is valid and ready.
- alu_wb_data / mem_wb_data / mul_wb_data  in  WORD_SIZE  writeback results.
- alu_wb_rob_id / mem_wb_rob_id / mul_wb_rob_id  in  ROB_ENTRY_WIDTH  writeback targets.
- alu_wb_bypass_enable / mem_wb_bypass_enable / mul_wb_bypass_enable  in  1  writeback strobes.
- commit  out  1  RF/RF_ROB write enable for the retiring non-store entry.
- commit_rd  out  ARCH_REG_INDEX_SIZE  rd of the head entry.
- commit_rob_id  out  ROB_ENTRY_WIDTH  head pointer.
- din  out  WORD_SIZE  data of the head entry.
- store_commit  out  1  a store entry retires this cycle.
- empty  out  1  count == 0.

Behaviour:
- State per entry: valid, ready, is_store, rd, data. Global state: head, tail, count (ROB_ENTRY_WIDTH+1 bits).
- Reset (rst low, async): all valid/ready cleared; head = tail = count = 0.
  - Outputs at reset: full=0, empty=1, assigned_rob_id=0, commit=0, store_commit=0, commit_rob_id=0, commit_rd=0, din=0, rob_sX_valid=0.
- alloc = require_rob_entry & !full & !stall_in & !flush.
  - On the clock edge the entry at tail gets valid=1, ready=0, rd, is_store, data=0; tail increments modulo ROB_ENTRIES.
  - The ID is visible combinationally on assigned_rob_id during the allocation cycle.
  - Decode's rename write uses that same edge.
- Writeback: each enabled port sets ready=1 and data at its rob_id on the edge.
  - A write to an invalid entry is ignored.
  - Distinct IDs may write in the same cycle.
  - On a same-ID collision the priority is ALU > MEM > MUL.
  - A write to an already-ready entry overwrites its data.
- retire = valid[head] & ready[head] & !flush. All commit outputs are combinational from registered state only.
  - commit = retire & !is_store[head]; store_commit = retire & is_store[head].
  - commit_rd, commit_rob_id and din are driven from head, and are 0 when !retire.
  - On the edge: valid[head] cleared, head increments modulo ROB_ENTRIES.
  - At most one retirement per cycle.
- Latency:
  - Allocation to earliest commit is 2 edges: alloc edge, writeback edge; commit is visible in the following cycle.
  - A writeback in cycle N makes commit visible in cycle N+1 if the entry is at head.
- Lookups: rob_sX_data = data[rs_rob_entry]; rob_sX_valid = valid & ready of that entry.
  - Registered state only; no same-cycle writeback forwarding (the forward unit covers that).
- count' = count + alloc - retire.
  - full is combinational from count, so a full ROB blocks allocation even while retiring in the same cycle.
  - Empty: retire=0.
- Wrap-around: pointers roll from ROB_ENTRIES-1 to 0. Relative ordering uses only head and count, never pointer comparison.
- flush: synchronous; highest priority over alloc, writeback and retire.
  - Clears all valid bits; head = tail = count = 0.
  - commit/store_commit are forced 0 in the flush cycle.
- Reset asserted mid-operation: immediate return to reset state regardless of in-flight writebacks.

Test Plan:
- Reset, then alloc rd=5 → assigned_rob_id=0; ALU wb id0 data 0x1234 → next cycle commit=1, commit_rd=5, commit_rob_id=0, din=0x1234; empty=1 afterward.
- Allocate 8 (no writebacks) → full=1 and require_rob_entry is ignored (tail stays 0); wb id0 → retire frees one, full drops the following cycle, next alloc gets id 0.
- Out-of-order completion: alloc ids 0,1,2; MUL wb id2=7, ALU wb id1=6, MEM wb id0=5 in separate cycles → commits occur in order 0,1,2 with din 5,6,7.
- Store: alloc is_store=1 id0, MEM wb id0 → store_commit=1, commit=0.
- Lookup: after wb id3=0xAB, rs1_rob_entry=3 → rob_s1_valid=1, data 0xAB; rs2_rob_entry=4 (unwritten) → rob_s2_valid=0.
- Flush with 5 valid entries plus a same-cycle wb and alloc → next cycle empty=1, assigned_rob_id=0, no commit; wrap test after 20 alloc/retire pairs yields ids 0..7 repeating.
